control_unit: RTL and testbench
===============================

# control_unit

Instruction-sequencing state machine for the 16-bit processor; the consumer and driver of the program counter. It holds Clear/Up for the 7-bit PC, captures the instruction fetched at the PC address into its internal instruction register (IR), decodes it, and drives data-memory, register-file and ALU controls for one instruction at a time. It sits between the PC/instruction ROM and the datapath.

## Interface
- No parameters. Widths are fixed: 16-bit instruction, 8-bit data address, 4-bit register address, 3-bit ALU select.
- Clock  in  1  system clock, rising-edge.
- Reset  in  1  asynchronous, active-high reset.
- Instr  in  16  ROM word at the current PC value. Combinational read, valid in the same cycle as PC Q.
- PC_clr  out  1  to PC Clear.
- PC_up  out  1  to PC Up.
- IR_out  out  16  current IR contents.
- D_addr  out  8  data-memory address.
- D_wr  out  1  data-memory write enable.
- RF_s  out  1  RF write-data mux: 1 = memory data, 0 = ALU result.
- RF_W_addr  out  4  RF write address.
- RF_W_en  out  1  RF write enable.
- RF_Ra_addr  out  4  RF read port A address.
- RF_Rb_addr  out  4  RF read port B address.
- ALU_s0  out  3  ALU function: 0 = pass 0, 1 = A+B, 2 = A−B.
- State  out  4  current state encoding, for display and debug.
- Halted  out  1  high while in Halt.

## Operation
- Instruction format uses opcode IR[15:12].
  - 0000 NOOP.
  - 0001 STORE: D[IR[11:4]] <= R[IR[3:0]].
  - 0010 LOAD: R[IR[3:0]] <= D[IR[11:4]].
  - 0011 ADD: R[IR[3:0]] <= R[IR[11:8]] + R[IR[7:4]].
  - 0100 SUB: R[IR[3:0]] <= R[IR[11:8]] − R[IR[7:4]].
  - 0101 HALT.
  - 0110–1111 execute as NOOP.
- State encodings: Init=0, Fetch=1, Decode=2, NoOp=3, Load_A=4, Load_B=5, Store=6, Add=7, Sub=8, Halt=9.
- Transitions:
  - Init→Fetch.
  - Fetch→Decode.
  - Decode→NoOp, Store, Load_A, Add, Sub or Halt by opcode.
  - Load_A→Load_B.
  - NoOp, Load_B, Store, Add and Sub each go →Fetch.
  - Halt→Halt until Reset.
- Outputs are Moore: a function of state and IR only. Any output not listed for a state is 0.
  - Init: PC_clr=1.
  - Fetch: PC_up=1. IR <= Instr at the clock edge.
  - Decode, NoOp: none.
  - Store: D_addr=IR[11:4], RF_Ra_addr=IR[3:0], D_wr=1.
  - Load_A: D_addr=IR[11:4].
  - Load_B: D_addr=IR[11:4], RF_s=1, RF_W_addr=IR[3:0], RF_W_en=1.
  - Add: RF_Ra_addr=IR[11:8], RF_Rb_addr=IR[7:4], RF_W_addr=IR[3:0], RF_W_en=1, ALU_s0=1.
  - Sub: same as Add but ALU_s0=2.
  - Halt: Halted=1.
- The IR changes only in Fetch. It holds its value in all other states, including Halt.
- PC wrap (127→0) belongs to the PC. A program with no HALT simply wraps and continues.

## Timing
- Reset asserted: state=Init and IR=0 immediately, with no clock needed.
  - Outputs then: PC_clr=1, State=0, all others 0.
  - D_wr and RF_W_en drop in the same cycle Reset rises, even mid-Store, mid-Load_B, Add or Sub.
- First Fetch is the second rising edge after Reset deasserts: one edge leaves Init, the next captures the IR.
- Latency per instruction, counting Fetch through the last execute cycle:
  - NOOP, STORE, ADD, SUB: 3 cycles.
  - LOAD: 4 cycles, because data memory has 1-cycle synchronous read latency.
  - HALT: 2 cycles to reach Halt.
- PC_up is high for exactly one cycle per instruction, so the PC advances exactly once per instruction.
- D_wr and RF_W_en are single-cycle pulses. The write occurs on the rising edge that ends the state.

## Test plan
- Reset, then idle: Reset=1 for 2 cycles, then release. Expect State 0→1, PC_clr=1 only in Init, PC_up=1 only in Fetch, IR_out=0 before the first Fetch.
- NOOP stream: Instr=16'h0000 always. Expect State cycling 1,2,3,1,… and PC_up pulsing once every 3 cycles.
- LOAD: Instr=16'h2A53. Expect Load_A with D_addr=8'hA5, then Load_B with D_addr=8'hA5, RF_s=1, RF_W_addr=3, RF_W_en=1. Expect 4 cycles from Fetch to the next Fetch.
- ADD then SUB: 16'h3123 gives Ra=1, Rb=2, RF_W_addr=3, ALU_s0=1. 16'h4456 gives Ra=4, Rb=5, RF_W_addr=6, ALU_s0=2. RF_s=0 in both.
- HALT plus illegal opcode: 16'hF000 behaves as NOOP (State 3). 16'h5000 gives State=9 and Halted=1, and the machine stays there for 20 cycles with PC_up=0 and IR_out=16'h5000.
- Reset during STORE: Instr=16'h1FF2. Assert Reset in the Store cycle, mid-cycle. Expect D_wr to fall immediately, State=0, IR_out=0, and normal fetch after release.

Source files
------------

// File: rtl/control_unit.sv
// Instruction-sequencing FSM for the 16-bit processor: drives the PC, captures
// the fetched word into the IR, and issues one instruction's datapath controls at a time.
module control_unit (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] Instr,
    output logic        PC_clr,
    output logic        PC_up,
    output logic [15:0] IR_out,
    output logic [7:0]  D_addr,
    output logic        D_wr,
    output logic        RF_s,
    output logic [3:0]  RF_W_addr,
    output logic        RF_W_en,
    output logic [3:0]  RF_Ra_addr,
    output logic [3:0]  RF_Rb_addr,
    output logic [2:0]  ALU_s0,
    output logic [3:0]  State,
    output logic        Halted
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_INIT;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // The IR is loaded only on the edge that leaves Fetch.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH: begin
                state_d = S_DECODE;
                ir_d    = Instr;
            end
            S_DECODE: begin
                case (ir_q[15:12])
                    4'h1:    state_d = S_STORE;
                    4'h2:    state_d = S_LOAD_A;
                    4'h3:    state_d = S_ADD;
                    4'h4:    state_d = S_SUB;
                    4'h5:    state_d = S_HALT;
                    default: state_d = S_NOOP;
                endcase
            end
            S_LOAD_A: state_d = S_LOAD_B;
            S_NOOP, S_LOAD_B, S_STORE, S_ADD, S_SUB: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_INIT;
        endcase
    end

    always_comb begin
        PC_clr     = 1'b0;
        PC_up      = 1'b0;
        D_addr     = '0;
        D_wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_addr  = '0;
        RF_W_en    = 1'b0;
        RF_Ra_addr = '0;
        RF_Rb_addr = '0;
        ALU_s0     = '0;
        Halted     = 1'b0;
        case (state_q)
            S_INIT:   PC_clr = 1'b1;
            S_FETCH:  PC_up  = 1'b1;
            S_LOAD_A: D_addr = ir_q[11:4];
            S_LOAD_B: begin
                D_addr    = ir_q[11:4];
                RF_s      = 1'b1;
                RF_W_addr = ir_q[3:0];
                RF_W_en   = 1'b1;
            end
            S_STORE: begin
                D_addr     = ir_q[11:4];
                RF_Ra_addr = ir_q[3:0];
                D_wr       = 1'b1;
            end
            S_ADD, S_SUB: begin
                RF_Ra_addr = ir_q[11:8];
                RF_Rb_addr = ir_q[7:4];
                RF_W_addr  = ir_q[3:0];
                RF_W_en    = 1'b1;
                ALU_s0     = (state_q == S_ADD) ? 3'd1 : 3'd2;
            end
            S_HALT:   Halted = 1'b1;
            default:  ;
        endcase
    end

    assign State  = state_q;
    assign IR_out = ir_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-instruction state plans drive a reference model
// compared every cycle, plus directed literal checks from the test plan.
module tb_control_unit;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] Instr = 16'h0000;
    logic        PC_clr, PC_up, D_wr, RF_s, RF_W_en, Halted;
    logic [15:0] IR_out;
    logic [7:0]  D_addr;
    logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, State;
    logic [2:0]  ALU_s0;

    control_unit dut (
        .Clock(Clock), .Reset(Reset), .Instr(Instr),
        .PC_clr(PC_clr), .PC_up(PC_up), .IR_out(IR_out),
        .D_addr(D_addr), .D_wr(D_wr), .RF_s(RF_s),
        .RF_W_addr(RF_W_addr), .RF_W_en(RF_W_en),
        .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr),
        .ALU_s0(ALU_s0), .State(State), .Halted(Halted)
    );

    always #5 Clock = ~Clock;

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each fetched instruction expands into the list of
    // states it will visit after Fetch; the model just walks that list.
    int          m_state = 0;
    logic [15:0] m_ir    = 16'h0000;
    int          plan[$];

    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            m_state = 0;
            m_ir    = 16'h0000;
            plan.delete();
        end else if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1) begin
            m_ir = Instr;
            case (Instr[15:12])
                4'h1:    plan = {2, 6};
                4'h2:    plan = {2, 4, 5};
                4'h3:    plan = {2, 7};
                4'h4:    plan = {2, 8};
                4'h5:    plan = {2, 9};
                default: plan = {2, 3};
            endcase
            m_state = plan.pop_front();
        end else if (m_state == 9) begin
            m_state = 9;
        end else if (plan.size() > 0) begin
            m_state = plan.pop_front();
        end else begin
            m_state = 1;
        end
    end

    function automatic logic [48:0] expect_out(input int st, input logic [15:0] ir);
        logic       pcc, pcu, dw, rs, we, h;
        logic [7:0] da;
        logic [3:0] wa, ra, rb, sv;
        logic [2:0] alu;
        pcc = 0; pcu = 0; dw = 0; rs = 0; we = 0; h = 0;
        da = 0; wa = 0; ra = 0; rb = 0; alu = 0;
        sv = 4'(st);
        case (st)
            0: pcc = 1;
            1: pcu = 1;
            4: da = ir[11:4];
            5: begin da = ir[11:4]; rs = 1; wa = ir[3:0]; we = 1; end
            6: begin da = ir[11:4]; ra = ir[3:0]; dw = 1; end
            7, 8: begin
                ra = ir[11:8]; rb = ir[7:4]; wa = ir[3:0]; we = 1;
                alu = (st == 7) ? 3'd1 : 3'd2;
            end
            9: h = 1;
            default: ;
        endcase
        return {pcc, pcu, ir, da, dw, rs, wa, we, ra, rb, alu, sv, h};
    endfunction

    wire [48:0] dut_out = {PC_clr, PC_up, IR_out, D_addr, D_wr, RF_s, RF_W_addr,
                           RF_W_en, RF_Ra_addr, RF_Rb_addr, ALU_s0, State, Halted};

    always @(posedge Clock) begin
        #1;
        if (chk_en) check("cycle outputs", 64'(dut_out), 64'(expect_out(m_state, m_ir)));
    end

    task automatic wait_state(input logic [3:0] s, input int budget, input string name);
        int k;
        k = 0;
        do begin
            @(posedge Clock);
            #1;
            k++;
        end while (State !== s && k < budget);
        check(name, 64'(State), 64'(s));
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] r;
        r = 16'($urandom);
        if (r[15:12] == 4'h5) r[15:12] = 4'h0;
        return r;
    endfunction

    initial begin
        int n;
        int bad;
        chk_en = 1'b1;

        // Reset held two cycles
        repeat (2) @(posedge Clock);
        #1;
        check("reset State", 64'(State), 64'd0);
        check("reset PC_clr", 64'(PC_clr), 64'd1);
        check("reset PC_up", 64'(PC_up), 64'd0);
        check("reset IR_out", 64'(IR_out), 64'h0);
        @(negedge Clock) Reset = 1'b0;
        @(posedge Clock);
        #1;
        check("first Fetch State", 64'(State), 64'd1);
        check("IR before first fetch", 64'(IR_out), 64'h0);
        check("PC_clr off in Fetch", 64'(PC_clr), 64'd0);

        // NOOP stream: one PC_up per 3 cycles
        n = 0;
        repeat (9) begin
            @(posedge Clock);
            #1;
            n += int'(PC_up);
        end
        check("noop PC_up count", 64'(n), 64'd3);

        // LOAD 2A53
        @(negedge Clock) Instr = 16'h2A53;
        wait_state(4'd4, 10, "reach Load_A");
        check("Load_A D_addr", 64'(D_addr), 64'hA5);
        check("Load_A RF_W_en", 64'(RF_W_en), 64'd0);
        @(posedge Clock);
        #1;
        check("Load_B fields", 64'({State, D_addr, RF_s, RF_W_addr, RF_W_en}),
              64'({4'd5, 8'hA5, 1'b1, 4'd3, 1'b1}));
        wait_state(4'd1, 5, "fetch after load");
        n = 0;
        do begin
            @(posedge Clock);
            #1;
            n++;
        end while (State !== 4'd1 && n < 10);
        check("load latency", 64'(n), 64'd4);

        // ADD then SUB
        @(negedge Clock) Instr = 16'h3123;
        wait_state(4'd7, 10, "reach Add");
        check("Add fields", 64'({RF_Ra_addr, RF_Rb_addr, RF_W_addr, ALU_s0, RF_s, RF_W_en}),
              64'({4'd1, 4'd2, 4'd3, 3'd1, 1'b0, 1'b1}));
        @(negedge Clock) Instr = 16'h4456;
        wait_state(4'd8, 10, "reach Sub");
        check("Sub fields", 64'({RF_Ra_addr, RF_Rb_addr, RF_W_addr, ALU_s0, RF_s, RF_W_en}),
              64'({4'd4, 4'd5, 4'd6, 3'd2, 1'b0, 1'b1}));

        // Unused opcode behaves as NOOP
        @(negedge Clock) Instr = 16'hF000;
        wait_state(4'd3, 10, "illegal opcode NoOp");
        check("illegal IR_out", 64'(IR_out), 64'hF000);

        // Random instruction stream (no HALT)
        repeat (300) @(negedge Clock) Instr = rand_instr();

        // HALT holds for 20 cycles regardless of Instr
        @(negedge Clock) Instr = 16'h5000;
        wait_state(4'd9, 10, "reach Halt");
        bad = 0;
        repeat (20) begin
            @(negedge Clock) Instr = 16'($urandom);
            @(posedge Clock);
            #1;
            if ({State, PC_up, IR_out, Halted} !== {4'd9, 1'b0, 16'h5000, 1'b1}) bad++;
        end
        check("halt hold bad cycles", 64'(bad), 64'd0);

        // Reset in the middle of a Store cycle
        @(negedge Clock) Reset = 1'b1;
        @(negedge Clock) begin Reset = 1'b0; Instr = 16'h1FF2; end
        wait_state(4'd6, 10, "reach Store");
        check("Store D_wr", 64'({D_wr, D_addr, RF_Ra_addr}), 64'({1'b1, 8'hFF, 4'd2}));
        #2 Reset = 1'b1;
        #1;
        check("async reset outputs", 64'({D_wr, State, IR_out, PC_clr}),
              64'({1'b0, 4'd0, 16'h0, 1'b1}));
        @(negedge Clock) Reset = 1'b0;
        wait_state(4'd2, 5, "decode after reset");
        check("fetch after reset IR", 64'(IR_out), 64'h1FF2);

        // Second random stream with occasional async resets
        for (int i = 0; i < 400; i++) begin
            @(negedge Clock) Instr = rand_instr();
            if ($urandom_range(0, 60) == 0) begin
                #($urandom_range(1, 4)) Reset = 1'b1;
                @(negedge Clock) Reset = 1'b0;
            end
        end

        @(posedge Clock);
        #2;
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
